fifo_sample_unpacker: RTL and testbench
=======================================

Name: fifo_sample_unpacker

Overview:
- Downstream consumer of the tracking FIFO. Pops bytes through the FIFO read strobe and assembles them into multi-byte audio samples.
- Presents the samples on a valid/ready stream to the DAC serializer, tagged with a rotating channel index.
- Uses the FIFO write/read addresses to compute the fill level. A sample read burst starts only when a whole sample is buffered, so samples are never torn.

Parameters:
BYTES_PER_SAMPLE, 3, bytes per sample; legal 1..4
MSB_FIRST, 1, 1 = first popped byte is most significant; 0 = least significant first
SIGN_EXTEND, 1, 1 = sign-extend the assembled sample to 32 bits; 0 = zero-extend
CHANNELS, 2, channels interleaved in the byte stream; legal 1..8

Ports:
clk  in  1  single clock; the FIFO read side and this block share it
reset  in  1  asynchronous, active-high reset
fifo_data  in  8  FIFO read data; valid the cycle after fifo_read is high
fifo_addr_in  in  11  FIFO write address, already synchronous to clk
fifo_addr_out  in  11  FIFO read address; advances the cycle after each fifo_read
fifo_read  out  1  FIFO pop strobe, registered
sample_data  out  32  assembled sample, right-justified and extended
sample_channel  out  3  channel index of sample_data, 0..CHANNELS-1
sample_valid  out  1  sample_data/sample_channel valid
sample_ready  in  1  downstream accept
level  out  11  registered (fifo_addr_in - fifo_addr_out) mod 2048

Behaviour:
- Reset values: fifo_read=0, sample_data=0, sample_channel=0, sample_valid=0, level=0, state=IDLE, byte counter=0, shift register=0.
- level: registered every cycle as the 11-bit wrap-around difference. Wrap example: addr_in=0x002, addr_out=0x7FE gives level=4.
- IDLE:
  - If level >= BYTES_PER_SAMPLE, go to READ and set fifo_read=1.
  - Otherwise stay in IDLE with fifo_read=0.
- READ:
  - fifo_read stays high for exactly BYTES_PER_SAMPLE consecutive cycles; the byte counter counts the issued reads.
  - Then fifo_read drops and the state moves to DRAIN.
- Capture: a registered copy of fifo_read (rd_d) gates byte capture. Each cycle rd_d=1, fifo_data enters the shift register.
  - MSB_FIRST=1: shift left by 8, new byte in bits [7:0].
  - MSB_FIRST=0: new byte goes into byte lane k, where k = capture index.
- DRAIN: wait one cycle for the last byte to be captured, then go to PRESENT.
- PRESENT:
  - sample_data = assembled value of width 8*BYTES_PER_SAMPLE, extended to 32 bits per SIGN_EXTEND. sample_valid=1.
  - sample_data and sample_channel hold stable while sample_valid=1 and sample_ready=0.
  - On sample_valid & sample_ready: sample_valid drops next cycle; sample_channel increments and wraps CHANNELS-1 -> 0; state returns to IDLE.
- Latency: IDLE decision at cycle 0, reads at cycles 1..N, captures at cycles 2..N+1, sample_valid high at cycle N+2 (N = BYTES_PER_SAMPLE).
- Minimum spacing between samples is N+3 cycles. Re-evaluating level only in IDLE keeps the pointer lag safe.
- Empty: no read is ever issued unless level >= N, so the FIFO's refuse-on-empty path is never exercised.
- Full/wrap: level arithmetic is modulo 2048; this block does not detect overflow.
- sample_ready high before sample_valid has no effect.
- Reset mid-burst: all state clears immediately. Bytes already popped are discarded; the channel index returns to 0. Upstream must also reset the FIFO to keep channel alignment.

Test Plan:
- N=3, MSB_FIRST=1, SIGN_EXTEND=1; FIFO preloaded 0x80,0x00,0x01; sample_ready=1 -> fifo_read high exactly 3 cycles; sample_data=0xFF800001, channel 0, sample_valid at cycle 5.
- Same setup, MSB_FIRST=0, SIGN_EXTEND=0, bytes 0x01,0x02,0x83 -> sample_data=0x00830201.
- level=2 with N=3 -> fifo_read stays 0 indefinitely. Write a 3rd byte -> burst starts the cycle after level reads 3.
- Backpressure: sample_ready=0 for 10 cycles -> sample_valid, sample_data and sample_channel held stable, no fifo_read. Then ready=1 -> one transfer, channel becomes 1.
- Four samples, CHANNELS=2 -> channels 0,1,0,1. Pointer wrap with addr_out 0x7FE -> 0x001 -> level correct, data intact.
- Assert reset during the 2nd read cycle -> fifo_read=0 and sample_valid=0 immediately. After reset, a fresh 3-byte sample is assembled correctly on channel 0.

Source files
------------

// File: rtl/fifo_sample_unpacker.sv
// Pops whole samples from the tracking FIFO, assembles them from bytes and
// presents them on a valid/ready stream tagged with a rotating channel index.
module fifo_sample_unpacker #(
    parameter int BYTES_PER_SAMPLE = 3,
    parameter int MSB_FIRST        = 1,
    parameter int SIGN_EXTEND      = 1,
    parameter int CHANNELS         = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  fifo_data,
    input  logic [10:0] fifo_addr_in,
    input  logic [10:0] fifo_addr_out,
    output logic        fifo_read,
    output logic [31:0] sample_data,
    output logic [2:0]  sample_channel,
    output logic        sample_valid,
    input  logic        sample_ready,
    output logic [10:0] level
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_READ    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    localparam int          SAMPLE_W = 8 * BYTES_PER_SAMPLE;
    localparam logic [2:0]  LAST_IDX = 3'(BYTES_PER_SAMPLE - 1);
    localparam logic [2:0]  LAST_CH  = 3'(CHANNELS - 1);
    localparam logic [10:0] N_LVL    = 11'(BYTES_PER_SAMPLE);

    state_t      state_q;
    logic        fifo_read_q;
    logic        rd_q;
    logic [2:0]  cnt_q;
    logic [2:0]  cap_q;
    logic [31:0] shift_q;
    logic [31:0] shift_d;
    logic [10:0] level_q;
    logic [10:0] level_d;
    logic [31:0] sample_data_q;
    logic [2:0]  sample_channel_q;
    logic        sample_valid_q;
    logic        start_s;

    // Right-justified raw sample widened to 32 bits, sign or zero fill.
    function automatic logic [31:0] extend(input logic [31:0] raw);
        logic [31:0] r;
        logic        fill;
        fill = (SIGN_EXTEND != 0) ? raw[SAMPLE_W-1] : 1'b0;
        for (int i = 0; i < 32; i++) begin
            r[i] = (i < SAMPLE_W) ? raw[i] : fill;
        end
        return r;
    endfunction

    assign start_s = (state_q == ST_IDLE) && (level_q >= N_LVL);

    // Next shift-register contents: capture the byte returned one cycle after each pop.
    always_comb begin
        shift_d = shift_q;
        level_d = fifo_addr_in - fifo_addr_out;
        if (rd_q) begin
            if (MSB_FIRST != 0) begin
                shift_d = {shift_q[23:0], fifo_data};
            end else begin
                shift_d[{cap_q[1:0], 3'b000} +: 8] = fifo_data;
            end
        end else if (start_s) begin
            shift_d = 32'h0000_0000;
        end else begin
            shift_d = shift_q;
        end
    end

    // Burst sequencer, capture bookkeeping and registered stream outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            fifo_read_q      <= 1'b0;
            rd_q             <= 1'b0;
            cnt_q            <= 3'd0;
            cap_q            <= 3'd0;
            shift_q          <= 32'h0000_0000;
            level_q          <= 11'd0;
            sample_data_q    <= 32'h0000_0000;
            sample_channel_q <= 3'd0;
            sample_valid_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            rd_q    <= fifo_read_q;
            shift_q <= shift_d;
            if (rd_q) begin
                cap_q <= cap_q + 3'd1;
            end else if (start_s) begin
                cap_q <= 3'd0;
            end else begin
                cap_q <= cap_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // Only a fully buffered sample starts a burst, so the FIFO never runs dry.
                    if (level_q >= N_LVL) begin
                        state_q     <= ST_READ;
                        fifo_read_q <= 1'b1;
                        cnt_q       <= 3'd0;
                    end else begin
                        fifo_read_q <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (cnt_q == LAST_IDX) begin
                        fifo_read_q <= 1'b0;
                        state_q     <= ST_DRAIN;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    state_q        <= ST_PRESENT;
                    sample_valid_q <= 1'b1;
                    sample_data_q  <= extend(shift_d);
                end
                ST_PRESENT: begin
                    if (sample_ready) begin
                        sample_valid_q   <= 1'b0;
                        sample_channel_q <= (sample_channel_q == LAST_CH) ? 3'd0
                                                                          : sample_channel_q + 3'd1;
                        state_q          <= ST_IDLE;
                    end else begin
                        sample_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    fifo_read_q    <= 1'b0;
                    sample_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_read      = fifo_read_q;
    assign sample_data    = sample_data_q;
    assign sample_channel = sample_channel_q;
    assign sample_valid   = sample_valid_q;
    assign level          = level_q;

endmodule

// File: tb/tb_fifo_sample_unpacker.sv
// Bench: two unpacker instances (MSB-first/sign-extend and LSB-first/zero-extend),
// each fed by a behavioural FIFO, checked against a byte-queue reference model.
module tb_fifo_sample_unpacker;

    localparam int N  = 3;
    localparam int CH = 2;

    logic        clk = 1'b0;
    logic        reset;
    always #5 clk = ~clk;

    logic [7:0]  fifo_data_a, fifo_data_b;
    logic [10:0] addr_in_a, addr_out_a, addr_in_b, addr_out_b;
    logic [10:0] level_a, level_b, base_a, base_b;
    logic        fifo_read_a, fifo_read_b;
    logic [31:0] data_a, data_b;
    logic [2:0]  ch_a, ch_b;
    logic        valid_a, valid_b, ready_a, ready_b;
    logic [7:0]  mem_a [2048];
    logic [7:0]  mem_b [2048];
    logic        under_a = 1'b0;
    logic        under_b = 1'b0;

    logic [7:0]  bq_a [$];
    logic [7:0]  bq_b [$];
    int          cnt_a, cnt_b, run_a, run_b;
    int          errors = 0;
    int          checks = 0;

    typedef struct {
        logic [7:0]  b0, b1, b2;
        logic [31:0] exp_a, exp_b;
    } vec_t;
    vec_t tbl [6];

    fifo_sample_unpacker #(.BYTES_PER_SAMPLE(N), .MSB_FIRST(1), .SIGN_EXTEND(1), .CHANNELS(CH)) u_dut_a (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_a), .fifo_addr_in(addr_in_a),
        .fifo_addr_out(addr_out_a), .fifo_read(fifo_read_a), .sample_data(data_a),
        .sample_channel(ch_a), .sample_valid(valid_a), .sample_ready(ready_a), .level(level_a));

    fifo_sample_unpacker #(.BYTES_PER_SAMPLE(N), .MSB_FIRST(0), .SIGN_EXTEND(0), .CHANNELS(CH)) u_dut_b (
        .clk(clk), .reset(reset), .fifo_data(fifo_data_b), .fifo_addr_in(addr_in_b),
        .fifo_addr_out(addr_out_b), .fifo_read(fifo_read_b), .sample_data(data_b),
        .sample_channel(ch_b), .sample_valid(valid_b), .sample_ready(ready_b), .level(level_b));

    // FIFO read sides: data one cycle after the pop, read pointer advances likewise.
    always @(posedge clk) begin
        if (reset) begin
            addr_out_a  <= base_a;
            fifo_data_a <= 8'h00;
        end else if (fifo_read_a) begin
            if (addr_out_a == addr_in_a) under_a <= 1'b1;
            fifo_data_a <= mem_a[addr_out_a];
            addr_out_a  <= addr_out_a + 11'd1;
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            addr_out_b  <= base_b;
            fifo_data_b <= 8'h00;
        end else if (fifo_read_b) begin
            if (addr_out_b == addr_in_b) under_b <= 1'b1;
            fifo_data_b <= mem_b[addr_out_b];
            addr_out_b  <= addr_out_b + 11'd1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference sample value from N popped bytes using plain arithmetic.
    function automatic logic [31:0] ref_val(input logic [7:0] b0, input logic [7:0] b1,
                                            input logic [7:0] b2, input bit msb, input bit se);
        longint     v;
        logic [7:0] b [3];
        b[0] = b0; b[1] = b1; b[2] = b2;
        v = 64'd0;
        for (int i = 0; i < N; i++) begin
            if (msb) v = v * 64'd256 + longint'(b[i]);
            else     v = v + (longint'(b[i]) << (8 * i));
        end
        if (se && v >= (64'd1 << (8 * N - 1))) v = v - (64'd1 << (8 * N));
        return v[31:0];
    endfunction

    task automatic push_a(input logic [7:0] b);
        mem_a[addr_in_a] = b;
        addr_in_a = addr_in_a + 11'd1;
        bq_a.push_back(b);
    endtask

    task automatic push_b(input logic [7:0] b);
        mem_b[addr_in_b] = b;
        addr_in_b = addr_in_b + 11'd1;
        bq_b.push_back(b);
    endtask

    function automatic logic [31:0] front_a();
        if (bq_a.size() < N) return 32'hDEAD_BEEF;
        return ref_val(bq_a[0], bq_a[1], bq_a[2], 1'b1, 1'b1);
    endfunction

    function automatic logic [31:0] front_b();
        if (bq_b.size() < N) return 32'hDEAD_BEEF;
        return ref_val(bq_b[0], bq_b[1], bq_b[2], 1'b0, 1'b0);
    endfunction

    // One clock: score handshakes about to happen, then sample at the falling edge.
    task automatic tick();
        logic hs_a, hs_b, hold_a, hold_b;
        hs_a   = valid_a && ready_a && !reset;
        hs_b   = valid_b && ready_b && !reset;
        hold_a = valid_a && !ready_a && !reset;
        hold_b = valid_b && !ready_b && !reset;
        if (hs_a) begin
            check("a_data", data_a, front_a());
            check("a_chan", 32'(ch_a), 32'(cnt_a % CH));
            for (int i = 0; i < N && bq_a.size() > 0; i++) void'(bq_a.pop_front());
            cnt_a++;
        end
        if (hs_b) begin
            check("b_data", data_b, front_b());
            check("b_chan", 32'(ch_b), 32'(cnt_b % CH));
            for (int i = 0; i < N && bq_b.size() > 0; i++) void'(bq_b.pop_front());
            cnt_b++;
        end
        @(negedge clk);
        if (reset) begin
            bq_a.delete(); bq_b.delete();
            cnt_a = 0; cnt_b = 0; run_a = 0; run_b = 0;
        end else begin
            if (hold_a) begin
                check("a_hold_valid", 32'(valid_a), 32'd1);
                check("a_hold_data", data_a, front_a());
                check("a_hold_chan", 32'(ch_a), 32'(cnt_a % CH));
            end
            if (hold_b) begin
                check("b_hold_valid", 32'(valid_b), 32'd1);
                check("b_hold_data", data_b, front_b());
            end
            if (fifo_read_a) run_a++;
            else if (run_a != 0) begin check("a_burst_len", 32'(run_a), 32'(N)); run_a = 0; end
            if (fifo_read_b) run_b++;
            else if (run_b != 0) begin check("b_burst_len", 32'(run_b), 32'(N)); run_b = 0; end
        end
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_valid_a(input int budget);
        for (int i = 0; i < budget && !valid_a; i++) tick();
        check("a_valid_wait", 32'(valid_a), 32'd1);
    endtask

    initial begin
        tbl[0] = '{8'h80, 8'h00, 8'h01, 32'hFF80_0001, 32'h0001_0080};
        tbl[1] = '{8'h7F, 8'hFF, 8'hFF, 32'h007F_FFFF, 32'h00FF_FF7F};
        tbl[2] = '{8'h00, 8'h00, 8'h00, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 32'hFFFF_FFFF, 32'h00FF_FFFF};
        tbl[4] = '{8'h12, 8'h34, 8'h56, 32'h0012_3456, 32'h0056_3412};
        tbl[5] = '{8'h01, 8'h02, 8'h83, 32'h0001_0283, 32'h0083_0201};

        base_a = 11'd0; base_b = 11'd0; addr_in_a = 11'd0; addr_in_b = 11'd0;
        ready_a = 1'b1; ready_b = 1'b1; reset = 1'b1;
        cnt_a = 0; cnt_b = 0; run_a = 0; run_b = 0;
        tick(); tick();
        check("rst_fifo_read", 32'(fifo_read_a), 32'd0);
        check("rst_valid", 32'(valid_a), 32'd0);
        check("rst_data", data_a, 32'd0);
        check("rst_chan", 32'(ch_a), 32'd0);
        check("rst_level", 32'(level_a), 32'd0);
        check("rst_valid_b", 32'(valid_b), 32'd0);
        reset = 1'b0;
        tick();

        // Latency: decision at cycle 0, reads 1..3, valid at 5.
        push_a(8'h80); push_a(8'h00); push_a(8'h01);
        for (int i = 0; i < 8 && level_a != 11'd3; i++) tick();
        check("lat_level", 32'(level_a), 32'd3);
        check("lat_rd_c0", 32'(fifo_read_a), 32'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("lat_rd", 32'(fifo_read_a), 32'(k >= 1 && k <= 3));
            check("lat_valid", 32'(valid_a), 32'(k == 5));
            if (k == 5) begin
                check("lat_data", data_a, 32'hFF80_0001);
                check("lat_chan", 32'(ch_a), 32'd0);
            end
        end

        // LSB-first, zero-extended instance.
        push_b(8'h01); push_b(8'h02); push_b(8'h83);
        for (int i = 0; i < 20 && !valid_b; i++) tick();
        check("lsb_data", data_b, 32'h0083_0201);
        check("lsb_chan", 32'(ch_b), 32'd0);
        settle(6);

        // Two bytes buffered: no pop until the third arrives.
        push_a(8'h11); push_a(8'h22);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("partial_no_read", 32'(fifo_read_a), 32'd0);
        end
        check("partial_level", 32'(level_a), 32'd2);
        push_a(8'h33);
        for (int i = 0; i < 5 && level_a != 11'd3; i++) tick();
        check("partial_level3", 32'(level_a), 32'd3);
        tick();
        check("partial_start", 32'(fifo_read_a), 32'd1);
        wait_valid_a(10);
        settle(5);

        // Backpressure for 10 cycles with a further sample waiting in the FIFO.
        ready_a = 1'b0;
        push_a(8'hC0); push_a(8'hFF); push_a(8'hEE);
        wait_valid_a(15);
        push_a(8'h01); push_a(8'h02); push_a(8'h03);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", 32'(valid_a), 32'd1);
            check("bp_no_read", 32'(fifo_read_a), 32'd0);
        end
        ready_a = 1'b1;
        tick();
        check("bp_released", 32'(valid_a), 32'd0);
        check("bp_chan_next", 32'(ch_a), 32'd1);
        settle(15);

        // Table vectors on both instances in lockstep.
        for (int v = 0; v < 6; v++) begin
            push_a(tbl[v].b0); push_a(tbl[v].b1); push_a(tbl[v].b2);
            push_b(tbl[v].b0); push_b(tbl[v].b1); push_b(tbl[v].b2);
            wait_valid_a(15);
            check("tbl_a", data_a, tbl[v].exp_a);
            check("tbl_b_valid", 32'(valid_b), 32'd1);
            check("tbl_b", data_b, tbl[v].exp_b);
            settle(4);
        end

        // Pointer wrap: restart both pointers at 0x7FE.
        base_a = 11'h7FE; addr_in_a = 11'h7FE; base_b = 11'd0; addr_in_b = 11'd0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("wrap_level0", 32'(level_a), 32'd0);
        check("wrap_chan0", 32'(ch_a), 32'd0);
        for (int i = 0; i < 4; i++) push_a(8'(8'hA0 + 8'(i)));
        tick();
        check("wrap_level4", 32'(level_a), 32'd4);
        for (int i = 0; i < 8; i++) push_a(8'($urandom_range(0, 255)));
        for (int i = 0; i < 300 && cnt_a < 4; i++) begin
            ready_a = 1'($urandom_range(0, 1));
            tick();
        end
        check("wrap_samples", 32'(cnt_a), 32'd4);

        // Random traffic and random backpressure against the reference queue.
        begin
            int pushed;
            pushed = 0;
            for (int i = 0; i < 5000; i++) begin
                if (pushed < 120 && $urandom_range(0, 2) == 0) begin
                    push_a(8'($urandom_range(0, 255)));
                    push_b(8'($urandom_range(0, 255)));
                    pushed++;
                end
                ready_a = 1'($urandom_range(0, 1));
                ready_b = 1'($urandom_range(0, 1));
                tick();
                if (pushed == 120 && bq_a.size() == 0 && bq_b.size() == 0) break;
            end
            check("rand_drain", 32'(bq_a.size() + bq_b.size()), 32'd0);
        end

        // Reset during the second read cycle of a burst.
        ready_a = 1'b1; ready_b = 1'b1;
        settle(10);
        push_a(8'hAA); push_a(8'hBB); push_a(8'hCC);
        for (int i = 0; i < 10 && !fifo_read_a; i++) tick();
        tick();
        check("mid_rd2", 32'(fifo_read_a), 32'd1);
        base_a = 11'd0; addr_in_a = 11'd0; base_b = 11'd0; addr_in_b = 11'd0;
        reset = 1'b1;
        #1;
        check("mid_rst_read", 32'(fifo_read_a), 32'd0);
        check("mid_rst_valid", 32'(valid_a), 32'd0);
        check("mid_rst_chan", 32'(ch_a), 32'd0);
        tick(); tick();
        reset = 1'b0;
        tick();
        push_a(8'h80); push_a(8'h00); push_a(8'h01);
        wait_valid_a(15);
        check("post_rst_data", data_a, 32'hFF80_0001);
        check("post_rst_chan", 32'(ch_a), 32'd0);
        settle(5);

        check("underflow_a", 32'(under_a), 32'd0);
        check("underflow_b", 32'(under_b), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
